// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - three-requester sequencing arbiter for the shared memory port; optional MEM_ARB_ROUND_ROBIN_EN
module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_re,
  output logic [DATA_W-1:0] ic_data,
  output logic              ic_finish,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_data,
  input  logic [7:0]        dc_mask,
  input  logic              dc_we,
  input  logic              dc_re,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_finish,
  input  logic [ADDR_W-1:0] uc_addr,
  input  logic [DATA_W-1:0] uc_data,
  input  logic [7:0]        uc_mask,
  input  logic              uc_we,
  input  logic              uc_re,
  output logic [DATA_W-1:0] uc_rdata,
  output logic              uc_finish,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic [7:0]        bus_mask,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] in_bus_data,
  input  logic              in_bus_finish,
  output logic              arb_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Grant ids double as indices into w_req.
  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IC   = 2'd1;
  localparam logic [1:0] G_DC   = 2'd2;
  localparam logic [1:0] G_UC   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_data;
  logic [7:0]        r_bus_mask;
  logic              r_bus_we;
  logic              r_bus_re;
  logic [DATA_W-1:0] r_ic_data;
  logic [DATA_W-1:0] r_dc_rdata;
  logic [DATA_W-1:0] r_uc_rdata;
  logic              r_ic_finish;
  logic              r_dc_finish;
  logic              r_uc_finish;

  logic [3:0]        w_req;
  logic [1:0]        w_winner;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [7:0]        w_sel_mask;
  logic              w_sel_we;
  logic              w_sel_re;

  assign w_req = {uc_we | uc_re, dc_we | dc_re, ic_re, 1'b0};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_rr_hi names the requester currently at the top of the rotation ic -> dc -> uc -> ic.
  logic [1:0] r_rr_hi;
  logic [1:0] w_rr_mid;
  logic [1:0] w_rr_lo;

  function automatic logic [1:0] f_rr_next(input logic [1:0] id);
    case (id)
      G_IC:    return G_DC;
      G_DC:    return G_UC;
      default: return G_IC;
    endcase
  endfunction

  assign w_rr_mid = f_rr_next(r_rr_hi);
  assign w_rr_lo  = f_rr_next(w_rr_mid);

  // Rotating-priority winner: first requester found walking the rotation from r_rr_hi.
  always_comb begin
    w_winner = G_NONE;
    if (w_req[r_rr_hi])       w_winner = r_rr_hi;
    else if (w_req[w_rr_mid]) w_winner = w_rr_mid;
    else if (w_req[w_rr_lo])  w_winner = w_rr_lo;
  end

  // After a completion the owner drops to the bottom; reset starts with uc on top, matching fixed order's first pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_hi <= G_UC;
    end else if (r_state == S_RESP) begin
      r_rr_hi <= f_rr_next(r_grant);
    end
  end
`else
  // Fixed-priority winner: uc over dc over ic.
  always_comb begin
    w_winner = G_NONE;
    if (w_req[G_UC])      w_winner = G_UC;
    else if (w_req[G_DC]) w_winner = G_DC;
    else if (w_req[G_IC]) w_winner = G_IC;
  end
`endif

  // Mux the winner's request fields; write wins over read, icache reads a full beat.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_mask = 8'h00;
    w_sel_we   = 1'b0;
    w_sel_re   = 1'b0;
    case (w_winner)
      G_IC: begin
        w_sel_addr = ic_addr;
        w_sel_mask = 8'hFF;
        w_sel_re   = 1'b1;
      end
      G_DC: begin
        w_sel_addr = dc_addr;
        w_sel_data = dc_data;
        w_sel_mask = dc_mask;
        w_sel_we   = dc_we;
        w_sel_re   = dc_re & ~dc_we;
      end
      G_UC: begin
        w_sel_addr = uc_addr;
        w_sel_data = uc_data;
        w_sel_mask = uc_mask;
        w_sel_we   = uc_we;
        w_sel_re   = uc_re & ~uc_we;
      end
      default: ;
    endcase
  end

  // Sequencer: latch a winner in IDLE, hold the bus in BUSY, pulse the owner's finish in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= G_NONE;
      r_bus_addr  <= '0;
      r_bus_data  <= '0;
      r_bus_mask  <= 8'h00;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
      r_ic_data   <= '0;
      r_dc_rdata  <= '0;
      r_uc_rdata  <= '0;
      r_ic_finish <= 1'b0;
      r_dc_finish <= 1'b0;
      r_uc_finish <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_winner != G_NONE) begin
            r_grant    <= w_winner;
            r_bus_addr <= w_sel_addr;
            r_bus_data <= w_sel_data;
            r_bus_mask <= w_sel_mask;
            r_bus_we   <= w_sel_we;
            r_bus_re   <= w_sel_re;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (in_bus_finish) begin
            r_bus_we <= 1'b0;
            r_bus_re <= 1'b0;
            // Data is always captured; the pulse only goes out if the owner is still asking.
            case (r_grant)
              G_IC: begin
                r_ic_data   <= in_bus_data;
                r_ic_finish <= w_req[G_IC];
              end
              G_DC: begin
                r_dc_rdata  <= in_bus_data;
                r_dc_finish <= w_req[G_DC];
              end
              G_UC: begin
                r_uc_rdata  <= in_bus_data;
                r_uc_finish <= w_req[G_UC];
              end
              default: ;
            endcase
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ic_finish <= 1'b0;
          r_dc_finish <= 1'b0;
          r_uc_finish <= 1'b0;
          r_grant     <= G_NONE;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_addr  = r_bus_addr;
  assign bus_data  = r_bus_data;
  assign bus_mask  = r_bus_mask;
  assign bus_we    = r_bus_we;
  assign bus_re    = r_bus_re;
  assign ic_data   = r_ic_data;
  assign dc_rdata  = r_dc_rdata;
  assign uc_rdata  = r_uc_rdata;
  assign ic_finish = r_ic_finish;
  assign dc_finish = r_dc_finish;
  assign uc_finish = r_uc_finish;
  assign arb_busy  = (r_state != S_IDLE);

endmodule
